// File: rtl/lsu_mem_ctrl.sv
// Load/store controller for a word-organised data memory with 1-cycle read latency.
// Converts byte/half/word accesses on byte addresses into word accesses; sub-word
// stores are done as read-modify-write. One response pulse per accepted request.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_MemWrite,
    input  logic [31:0] mem_RD
);

    typedef enum logic [2:0] {StIdle, StIssue, StCapture, StWr, StResp} state_e;

    localparam logic [30:0] MemWordsL = 31'(MEM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept = (state_q == StIdle) && req_valid;

    // Request error classification, checked against the live request at accept.
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11) begin
            req_err = 1'b1;
        end else if (req_size == 2'b01 && req_addr[0]) begin
            req_err = 1'b1;
        end else if (req_size == 2'b10 && req_addr[1:0] != 2'b00) begin
            req_err = 1'b1;
        end else if ({1'b0, req_addr[31:2]} >= MemWordsL) begin
            req_err = 1'b1;
        end
    end

    // Lane select and extension of the returned memory word for loads.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        unique case (addr_q[1:0])
            2'd0:    b = mem_RD[7:0];
            2'd1:    b = mem_RD[15:8];
            2'd2:    b = mem_RD[23:16];
            default: b = mem_RD[31:24];
        endcase
        h = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
        case (size_q)
            2'b00:   load_data = signed_q ? {{24{b[7]}}, b} : {24'b0, b};
            2'b01:   load_data = signed_q ? {{16{h[15]}}, h} : {16'b0, h};
            default: load_data = mem_RD;
        endcase
    end

    // Read-modify-write merge: replace the target lane(s) of the read word.
    always_comb begin
        merge_data = mem_RD;
        if (size_q == 2'b00) begin
            unique case (addr_q[1:0])
                2'd0:    merge_data[7:0]   = wdata_q[7:0];
                2'd1:    merge_data[15:8]  = wdata_q[7:0];
                2'd2:    merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) begin
                merge_data[31:16] = wdata_q[15:0];
            end else begin
                merge_data[15:0] = wdata_q[15:0];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_write && req_size == 2'b10) begin
                        state_d = StWr;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue:   state_d = StCapture;
            StCapture: state_d = StResp;
            StWr:      state_d = StResp;
            StResp:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State register, request capture and registered load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
                rdata_q  <= '0;
            end else if (state_q == StCapture) begin
                rdata_q <= write_q ? '0 : load_data;
            end
        end
    end

    // Response and memory-side outputs. Write enable is gated by reset so an
    // interrupted RMW can never reach its write edge.
    always_comb begin
        req_ready    = (state_q == StIdle);
        rsp_valid    = (state_q == StResp);
        rsp_err      = (state_q == StResp) && err_q;
        rsp_rdata    = (state_q == StResp) ? rdata_q : '0;
        mem_A        = '0;
        mem_WD       = '0;
        mem_MemWrite = 1'b0;
        if (state_q == StIssue || state_q == StCapture || state_q == StWr) begin
            mem_A = {2'b00, addr_q[31:2]};
        end
        if (state_q == StWr) begin
            mem_MemWrite = rst_n;
            mem_WD       = wdata_q;
        end else if (state_q == StCapture && write_q) begin
            mem_MemWrite = rst_n;
            mem_WD       = merge_data;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

    localparam int unsigned MEM_WORDS = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_MemWrite;
    logic [31:0] mem_RD;

    int total = 0;
    int bad   = 0;

    lsu_mem_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_A        (mem_A),
        .mem_WD       (mem_WD),
        .mem_MemWrite (mem_MemWrite),
        .mem_RD       (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behaviour: registered read, write on rising edge; poke port for preload.
    logic [31:0] mem [MEM_WORDS];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_idx = '0;
    logic [31:0] poke_data = '0;
    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_data;
        else if (mem_MemWrite) mem[mem_A[9:0]] <= mem_WD;
        mem_RD <= mem[mem_A[9:0]];
    end

    // Reference memory contents as the bench expects them.
    logic [31:0] ref_mem [MEM_WORDS];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic poke(input int idx, input logic [31:0] data);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = 10'(idx); poke_data = data;
        ref_mem[idx] = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // One request through the DUT, checked against the reference rules.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] got_rd, output logic [31:0] got_wd);
        logic [31:0] idx, old, mask, exp_rd, exp_wd;
        logic        exp_err, got_err;
        int          sh, exp_lat, lat, nwr, exp_nwr;
        idx = {2'b00, addr[31:2]};
        exp_err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
                  (sz == 2'b10 && addr[1:0] != 2'b00) || (idx >= MEM_WORDS);
        old  = exp_err ? 32'h0 : ref_mem[idx[9:0]];
        sh   = (sz == 2'b00) ? 8 * int'(addr[1:0]) : (sz == 2'b01) ? 16 * int'(addr[1]) : 0;
        mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        exp_rd = 0; exp_wd = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (wr) begin
            exp_lat = (sz == 2'b10) ? 2 : 3;
            exp_wd  = (old & ~(mask << sh)) | ((wd & mask) << sh);
        end else begin
            exp_lat = 3;
            exp_rd  = (old >> sh) & mask;
            if (sg && sz == 2'b00 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
            if (sg && sz == 2'b01 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
        end
        exp_nwr = (wr && !exp_err) ? 1 : 0;

        @(negedge clk);
        req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; nwr = 0; got_rd = 0; got_wd = 0; got_err = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            if (mem_MemWrite === 1'b1) begin
                nwr++;
                got_wd = mem_WD;
                total++;
                if (mem_A !== idx) begin
                    bad++; $display("FAIL mem_A_write: got %h want %h", mem_A, idx);
                end
            end
            if (rsp_valid === 1'b1) begin
                lat = c; got_rd = rsp_rdata; got_err = rsp_err;
            end else begin
                @(negedge clk);
            end
        end
        total++;
        if (lat != exp_lat) begin
            bad++; $display("FAIL rsp_latency addr=%h: got %0d want %0d", addr, lat, exp_lat);
        end
        total++;
        if (got_err !== exp_err) begin
            bad++; $display("FAIL rsp_err addr=%h sz=%0d: got %b want %b", addr, sz, got_err, exp_err);
        end
        total++;
        if (got_rd !== exp_rd) begin
            bad++; $display("FAIL rsp_rdata addr=%h sz=%0d: got %h want %h", addr, sz, got_rd, exp_rd);
        end
        total++;
        if (nwr != exp_nwr) begin
            bad++; $display("FAIL write_count addr=%h: got %0d want %0d", addr, nwr, exp_nwr);
        end
        if (exp_nwr == 1) begin
            total++;
            if (got_wd !== exp_wd) begin
                bad++; $display("FAIL mem_WD addr=%h: got %h want %h", addr, got_wd, exp_wd);
            end
            ref_mem[idx[9:0]] = exp_wd;
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL rsp_one_cycle: got valid=%b ready=%b want valid=0 ready=1",
                            rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        #3;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        total++; if (mem_MemWrite !== 1'b0) begin bad++; $display("FAIL reset_memwrite: got %b want 0", mem_MemWrite); end
        total++; if (mem_A !== 32'h0) begin bad++; $display("FAIL reset_mem_A: got %h want 0", mem_A); end
        total++; if (mem_WD !== 32'h0) begin bad++; $display("FAIL reset_mem_WD: got %h want 0", mem_WD); end
        for (int i = 0; i < 16; i++) poke(i, (i == 5) ? 32'h8899_AABB : $urandom);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [31:0] rd, wd;
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, wd);
        total++; if (rd !== 32'h8899_AABB) begin bad++; $display("FAIL lw_0x14: got %h want 8899aabb", rd); end
        do_req(1'b0, 2'b00, 1'b1, 32'h17, 32'h0, rd, wd);
        total++; if (rd !== 32'hFFFF_FF88) begin bad++; $display("FAIL lb_0x17: got %h want ffffff88", rd); end
        do_req(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, rd, wd);
        total++; if (rd !== 32'h0000_00BB) begin bad++; $display("FAIL lbu_0x14: got %h want 000000bb", rd); end
        do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, rd, wd);
        total++; if (rd !== 32'hFFFF_8899) begin bad++; $display("FAIL lh_0x16: got %h want ffff8899", rd); end
        do_req(1'b1, 2'b00, 1'b0, 32'h15, 32'h5A, rd, wd);
        total++; if (wd !== 32'h8899_5ABB) begin bad++; $display("FAIL sb_0x15: got %h want 88995abb", wd); end
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234, rd, wd);
        total++; if (wd !== 32'h1234_5ABB) begin bad++; $display("FAIL sh_0x16: got %h want 12345abb", wd); end
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, wd);
        total++; if (rd !== 32'h1234_5ABB) begin bad++; $display("FAIL lw_after_st: got %h want 12345abb", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd, wd;
        do_req(1'b0, 2'b01, 1'b0, 32'h15, 32'h0, rd, wd);
        do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEAD_BEEF, rd, wd);
        do_req(1'b0, 2'b11, 1'b0, 32'h14, 32'h0, rd, wd);
        do_req(1'b1, 2'b11, 1'b0, 32'h14, 32'hFFFF_FFFF, rd, wd);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h14;
        req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (mem_MemWrite !== 1'b1) begin
            bad++; $display("FAIL rmw_capture_write: got %b want 1", mem_MemWrite);
        end
        rst_n = 1'b0;
        #1;
        total++; if (mem_MemWrite !== 1'b0) begin bad++; $display("FAIL midreset_memwrite: got %b want 0", mem_MemWrite); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b want 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0 || mem_MemWrite !== 1'b0 || req_ready !== 1'b1) begin
                bad++; $display("FAIL midreset_hold: got valid=%b wr=%b ready=%b want 0 0 1",
                                rsp_valid, mem_MemWrite, req_ready);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_rsp: got %b want 0", rsp_valid); end
        end
        total++;
        if (mem[5] !== ref_mem[5]) begin
            bad++; $display("FAIL midreset_word5: got %h want %h", mem[5], ref_mem[5]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] wd, exp_ld;
        logic        exp_ready, exp_rsp, exp_wr;
        wd = $urandom;
        exp_ld = ref_mem[8];
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h20;
        req_wdata = '0; req_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_write = 1'b1; req_addr = 32'h24; req_wdata = wd;
            end
            if (c == 5) req_valid = 1'b0;
            exp_ready = (c == 4 || c == 7);
            exp_rsp   = (c == 3 || c == 6);
            exp_wr    = (c == 5);
            total++;
            if (req_ready !== exp_ready) begin
                bad++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, req_ready, exp_ready);
            end
            total++;
            if (rsp_valid !== exp_rsp) begin
                bad++; $display("FAIL b2b_rsp_valid c=%0d: got %b want %b", c, rsp_valid, exp_rsp);
            end
            total++;
            if (mem_MemWrite !== exp_wr) begin
                bad++; $display("FAIL b2b_memwrite c=%0d: got %b want %b", c, mem_MemWrite, exp_wr);
            end
            if (c == 3) begin
                total++;
                if (rsp_rdata !== exp_ld) begin
                    bad++; $display("FAIL b2b_load_data: got %h want %h", rsp_rdata, exp_ld);
                end
            end
            if (c == 5) begin
                total++;
                if (mem_WD !== wd || mem_A !== 32'd9) begin
                    bad++; $display("FAIL b2b_store: got A=%h WD=%h want A=9 WD=%h", mem_A, mem_WD, wd);
                end
            end
            if (c == 6) begin
                total++;
                if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
                    bad++; $display("FAIL b2b_store_rsp: got err=%b rdata=%h want 0 0", rsp_err, rsp_rdata);
                end
            end
        end
        ref_mem[9] = wd;
    endtask

    task automatic test_random;
        logic [31:0] rd, wd, addr;
        logic [1:0]  sz;
        int          r;
        for (int n = 0; n < 60; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 9) ? 2'(r % 3) : 2'b11;
            if ($urandom_range(0, 9) == 0) begin
                addr = 32'h1000 + 32'($urandom_range(0, 4095));
            end else begin
                addr = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'b01) addr[0] = 1'b0;
                    if (sz == 2'b10) addr[1:0] = 2'b00;
                end
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, rd, wd);
        end
        // Final sweep: every test word reads back as the model expects.
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, 2'b10, 1'b0, 32'(i * 4), 32'h0, rd, wd);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_errors;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
